// File: rtl/psg_pkg.sv
// psg_pkg
// Shared definitions for the SN76489-compatible PSG host register interface.
// Holds the register type codes, the noise channel index, reset constants
// and the packed latch type {ch[1:0], type} that records which register a
// data byte will land in.
package psg_pkg;

   // Register type carried in bit 4 of a latch byte.
   typedef enum logic {
      TONE = 1'b0,
      ATTN = 1'b1
   } psg_reg_type_e;

   // Channel 3 is the noise channel: its "tone" register is the noise control.
   localparam logic [1:0] NOISE_CH         = 2'd3;

   localparam logic [3:0] ATTN_SILENT      = 4'hF;
   localparam logic [2:0] NOISE_CTRL_RESET = 3'b000;

   // Mirrors data[6:4] of a latch byte bit for bit.
   typedef struct packed {
      logic [1:0]    ch;
      psg_reg_type_e kind;
   } psg_latch_t;

   localparam psg_latch_t LATCH_RESET = '{ch: 2'd0, kind: TONE};

   // True when the latch points at the noise control register.
   function automatic logic isNoiseTarget(input psg_latch_t l);
      return (l.ch == NOISE_CH) && (l.kind == TONE);
   endfunction

endpackage

// File: rtl/psg_write_strobe.sv
// psg_write_strobe
// Turns the host's active-low write strobe into a one-cycle write pulse on
// each falling edge and presents the data byte that goes with it.
//
// Configuration macro: PSG_WE_SYNC_EN
//   defined   - we_n and data pass through a 2-flop synchronizer first
//               (two extra cycles of latency; host holds data while we_n low)
//   undefined - we_n and data are treated as synchronous to clk
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous reset, active-high
//   data_i       in   host write data
//   weN_i        in   host write strobe, active low
//   writePulse_o out  one-cycle pulse per falling edge of the strobe
//   writeData_o  out  data byte belonging to the pulse
module psg_write_strobe (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] data_i,
   input  logic       weN_i,
   output logic       writePulse_o,
   output logic [7:0] writeData_o
);

   logic weCur;
   logic weHist_q;

`ifdef PSG_WE_SYNC_EN
   logic [1:0] weSync_q;
   logic [7:0] dataSync1_q;
   logic [7:0] dataSync2_q;

   // Two-stage synchronizer; the strobe resets high so no false edge appears.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         weSync_q    <= 2'b11;
         dataSync1_q <= 8'h00;
         dataSync2_q <= 8'h00;
      end else begin
         weSync_q    <= {weSync_q[0], weN_i};
         dataSync1_q <= data_i;
         dataSync2_q <= dataSync1_q;
      end
   end

   assign weCur       = weSync_q[1];
   assign writeData_o = dataSync2_q;
`else
   assign weCur       = weN_i;
   assign writeData_o = data_i;
`endif

   // History resets to 1 so a strobe already low at reset release is not an edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         weHist_q <= 1'b1;
      end else begin
         weHist_q <= weCur;
      end
   end

   assign writePulse_o = weHist_q & ~weCur;

endmodule

// File: rtl/psg_register_writer.sv
// psg_register_writer
// Host-side register interface for the SN76489-compatible PSG. Decodes the
// latch/data byte protocol into the register file (3 tone periods,
// 4 attenuations, 3-bit noise control), pulses reset_lfsr for one cycle on
// every noise control write and holds ready low for READY_CYCLES cycles
// after each accepted write.
//
// Configuration macro: PSG_WE_SYNC_EN (see psg_write_strobe).
//
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous reset, active-high
//   data           in   host write data
//   we_n           in   host write strobe, active low
//   ready          out  high = next write will be accepted
//   tone0..2_freq  out  tone period per channel (COUNTER_BITS)
//   attn0..3       out  attenuation per channel, attn3 is noise (ATTN_BITS)
//   noise_control  out  {FB, NF1, NF0}
//   reset_lfsr     out  one-cycle pulse on every noise control write
module psg_register_writer
   import psg_pkg::*;
#(
   parameter int COUNTER_BITS = 10,
   parameter int ATTN_BITS    = 4,
   parameter int READY_CYCLES = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [7:0]              data,
   input  logic                    we_n,
   output logic                    ready,
   output logic [COUNTER_BITS-1:0] tone0_freq,
   output logic [COUNTER_BITS-1:0] tone1_freq,
   output logic [COUNTER_BITS-1:0] tone2_freq,
   output logic [ATTN_BITS-1:0]    attn0,
   output logic [ATTN_BITS-1:0]    attn1,
   output logic [ATTN_BITS-1:0]    attn2,
   output logic [ATTN_BITS-1:0]    attn3,
   output logic [2:0]              noise_control,
   output logic                    reset_lfsr
);

   localparam int BUSY_BITS = $clog2(READY_CYCLES + 1);
   localparam int HI_BITS   = COUNTER_BITS - 4;

   logic       writePulse;
   logic [7:0] writeData;

   psg_write_strobe uStrobe (
      .clk          (clk),
      .reset        (reset),
      .data_i       (data),
      .weN_i        (we_n),
      .writePulse_o (writePulse),
      .writeData_o  (writeData)
   );

   logic [COUNTER_BITS-1:0] tone_q [3];
   logic [COUNTER_BITS-1:0] tone_d [3];
   logic [ATTN_BITS-1:0]    attn_q [4];
   logic [ATTN_BITS-1:0]    attn_d [4];
   logic [2:0]              noise_q, noise_d;
   psg_latch_t              latch_q, latch_d;
   logic [BUSY_BITS-1:0]    busy_q, busy_d;
   logic                    ready_q, ready_d;
   logic                    pulse_q, pulse_d;

   logic       accept;
   logic       isLatch;
   psg_latch_t target;

   // A latch byte targets the register it names; a data byte reuses the latch.
   assign accept  = writePulse & ready_q;
   assign isLatch = writeData[7];
   assign target  = isLatch ? psg_latch_t'(writeData[6:4]) : latch_q;

   // Latch bytes fill the low nibble of a tone period, data bytes the upper bits.
   function automatic logic [COUNTER_BITS-1:0] mergeTone(
      input logic [COUNTER_BITS-1:0] old,
      input logic                    lowNibble,
      input logic [7:0]              byteIn
   );
      logic [COUNTER_BITS-1:0] result;
      result = old;
      if (lowNibble) begin
         result[3:0] = byteIn[3:0];
      end else begin
         result[COUNTER_BITS-1:4] = HI_BITS'(byteIn[5:0]);
      end
      return result;
   endfunction

   // Next-state decode. An accepted write updates one register, restarts the
   // busy window and drops ready; otherwise the busy counter runs down to zero
   // and stays there, raising ready on the step from 1 to 0.
   always_comb begin
      tone_d  = tone_q;
      attn_d  = attn_q;
      noise_d = noise_q;
      latch_d = latch_q;
      busy_d  = busy_q;
      ready_d = ready_q;
      pulse_d = 1'b0;
      if (accept) begin
         if (isLatch) begin
            latch_d = target;
         end
         if (target.kind == ATTN) begin
            attn_d[target.ch] = ATTN_BITS'(writeData[3:0]);
         end else if (isNoiseTarget(target)) begin
            noise_d = writeData[2:0];
            pulse_d = 1'b1;
         end else begin
            case (target.ch)
               2'd0:    tone_d[0] = mergeTone(tone_q[0], isLatch, writeData);
               2'd1:    tone_d[1] = mergeTone(tone_q[1], isLatch, writeData);
               default: tone_d[2] = mergeTone(tone_q[2], isLatch, writeData);
            endcase
         end
         busy_d  = BUSY_BITS'(READY_CYCLES);
         ready_d = 1'b0;
      end else if (busy_q != '0) begin
         busy_d  = busy_q - 1'b1;
         ready_d = (busy_q == BUSY_BITS'(1));
      end
   end

   // Register file and handshake state; reset silences every channel.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tone_q  <= '{default: '0};
         attn_q  <= '{default: '1};
         noise_q <= NOISE_CTRL_RESET;
         latch_q <= LATCH_RESET;
         busy_q  <= '0;
         ready_q <= 1'b1;
         pulse_q <= 1'b0;
      end else begin
         tone_q  <= tone_d;
         attn_q  <= attn_d;
         noise_q <= noise_d;
         latch_q <= latch_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
         pulse_q <= pulse_d;
      end
   end

   assign ready         = ready_q;
   assign tone0_freq    = tone_q[0];
   assign tone1_freq    = tone_q[1];
   assign tone2_freq    = tone_q[2];
   assign attn0         = attn_q[0];
   assign attn1         = attn_q[1];
   assign attn2         = attn_q[2];
   assign attn3         = attn_q[3];
   assign noise_control = noise_q;
   assign reset_lfsr    = pulse_q;

endmodule

// File: tb/tb_psg_register_writer.sv
// tb_psg_register_writer
// Directed bench for psg_register_writer: reset values, tone latch/data
// pairs, attenuation latch retention, noise writes with reset_lfsr pulses,
// dropped strobes while busy, a long-held strobe and reset during busy.
module tb_psg_register_writer;

   logic       clock;
   logic       reset;
   logic [7:0] data;
   logic       weN;
   logic       ready;
   logic [9:0] tone0Freq, tone1Freq, tone2Freq;
   logic [3:0] attn0, attn1, attn2, attn3;
   logic [2:0] noiseControl;
   logic       resetLfsr;

   int testsRun   = 0;
   int testsFailed = 0;
   int pulseCount = 0;
   int lowCount;
   int pulseBase;
   int accepts;
   logic prevReady;

   psg_register_writer #(
      .COUNTER_BITS (10),
      .ATTN_BITS    (4),
      .READY_CYCLES (32)
   ) dut (
      .clk           (clock),
      .reset         (reset),
      .data          (data),
      .we_n          (weN),
      .ready         (ready),
      .tone0_freq    (tone0Freq),
      .tone1_freq    (tone1Freq),
      .tone2_freq    (tone2Freq),
      .attn0         (attn0),
      .attn1         (attn1),
      .attn2         (attn2),
      .attn3         (attn3),
      .noise_control (noiseControl),
      .reset_lfsr    (resetLfsr)
   );

   // 100 MHz clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Count every cycle in which reset_lfsr is seen high.
   always @(negedge clock) begin
      if (resetLfsr === 1'b1) pulseCount++;
   end

   // Hard stop in case a wait somewhere never completes.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Wait (bounded) for ready to return high, then record that it did.
   task automatic waitReady();
      for (int i = 0; i < 100; i++) begin
         if (ready === 1'b1) break;
         @(negedge clock);
      end
      checkOutput("readyReturn", ready, 1);
   endtask

   // One host write, strobe low for 3 cycles; lowCount gets the number of
   // cycles ready was observed low before it came back.
   task automatic applyStimulus(input logic [7:0] value);
      logic sawLow;
      sawLow   = 1'b0;
      lowCount = 0;
      @(negedge clock);
      data = value;
      weN  = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clock);
         if (i == 2) weN = 1'b1;
         if (ready === 1'b0) begin
            lowCount++;
            sawLow = 1'b1;
         end else if (sawLow) begin
            break;
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      data  = 8'h00;
      weN   = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      // Reset state
      checkOutput("rstTone0", tone0Freq, 10'h000);
      checkOutput("rstTone1", tone1Freq, 10'h000);
      checkOutput("rstTone2", tone2Freq, 10'h000);
      checkOutput("rstAttn0", attn0, 4'hF);
      checkOutput("rstAttn1", attn1, 4'hF);
      checkOutput("rstAttn2", attn2, 4'hF);
      checkOutput("rstAttn3", attn3, 4'hF);
      checkOutput("rstNoise", noiseControl, 3'b000);
      checkOutput("rstReady", ready, 1);
      checkOutput("rstPulse", resetLfsr, 0);

      // Channel 0 tone: latch low nibble E, then upper bits 0F -> 0x0FE
      applyStimulus(8'h8E);
      checkOutput("busyLen8E", lowCount, 32);
      checkOutput("tone0Low", tone0Freq, 10'h00E);
      applyStimulus(8'h0F);
      checkOutput("busyLen0F", lowCount, 32);
      checkOutput("tone0Full", tone0Freq, 10'h0FE);
      checkOutput("tone1Idle", tone1Freq, 10'h000);
      checkOutput("tone2Idle", tone2Freq, 10'h000);

      // Channel 2 attenuation latch, then data bytes reuse the latch
      applyStimulus(8'hD5);
      checkOutput("attn2Latch", attn2, 4'h5);
      applyStimulus(8'h03);
      checkOutput("attn2Data", attn2, 4'h3);
      applyStimulus(8'h0A);
      checkOutput("attn2Again", attn2, 4'hA);
      checkOutput("tone2Kept", tone2Freq, 10'h000);
      checkOutput("attn0Kept", attn0, 4'hF);
      checkOutput("tone0Kept", tone0Freq, 10'h0FE);

      // Noise control writes, one reset_lfsr pulse each
      pulseBase = pulseCount;
      applyStimulus(8'hE6);
      checkOutput("noiseLatch", noiseControl, 3'b110);
      checkOutput("pulseFirst", pulseCount - pulseBase, 1);
      applyStimulus(8'h01);
      checkOutput("noiseData", noiseControl, 3'b001);
      checkOutput("pulseSecond", pulseCount - pulseBase, 2);
      checkOutput("attn3Kept", attn3, 4'hF);

      // A strobe edge 10 cycles into the busy window is dropped
      @(negedge clock);
      data = 8'h85;
      weN  = 1'b0;
      repeat (3) @(negedge clock);
      weN = 1'b1;
      repeat (7) @(negedge clock);
      checkOutput("busyAt10", ready, 0);
      pulseBase = pulseCount;
      data = 8'hE7;
      weN  = 1'b0;
      repeat (3) @(negedge clock);
      weN = 1'b1;
      waitReady();
      repeat (3) @(negedge clock);
      checkOutput("tone0After85", tone0Freq, 10'h0F5);
      checkOutput("ignoredNoise", noiseControl, 3'b001);
      checkOutput("ignoredPulse", pulseCount - pulseBase, 0);

      // Strobe held low for 100 cycles: a single accept of data byte 02
      @(negedge clock);
      accepts   = 0;
      prevReady = ready;
      data = 8'h02;
      weN  = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (prevReady && !ready) accepts++;
         prevReady = ready;
      end
      weN = 1'b1;
      waitReady();
      repeat (40) @(negedge clock);
      checkOutput("heldAccepts", accepts, 1);
      checkOutput("heldTone0", tone0Freq, 10'h025);
      checkOutput("heldReady", ready, 1);

      // Reset 5 cycles into a busy window after an attenuation write
      @(negedge clock);
      data = 8'hB0;
      weN  = 1'b0;
      repeat (3) @(negedge clock);
      weN = 1'b1;
      repeat (2) @(negedge clock);
      checkOutput("midBusyReady", ready, 0);
      checkOutput("midBusyAttn1", attn1, 4'h0);
      pulseBase = pulseCount;
      #2;
      reset = 1'b1;
      #1;
      checkOutput("asyncReady", ready, 1);
      checkOutput("asyncAttn0", attn0, 4'hF);
      checkOutput("asyncAttn1", attn1, 4'hF);
      checkOutput("asyncAttn2", attn2, 4'hF);
      checkOutput("asyncAttn3", attn3, 4'hF);
      checkOutput("asyncTone0", tone0Freq, 10'h000);
      checkOutput("asyncNoise", noiseControl, 3'b000);
      checkOutput("asyncPulse", resetLfsr, 0);
      @(negedge clock);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      checkOutput("postRstPulse", pulseCount - pulseBase, 0);
      checkOutput("postRstReady", ready, 1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/psg_register_writer.md
Name: psg_register_writer

Overview:
- Host-side register interface for the SN76489-compatible PSG.
- Accepts CPU byte writes (latch/data protocol) on an 8-bit bus with an active-low write strobe.
- Maintains the PSG register file: 3 tone periods, 4 attenuations, 3-bit noise control.
- Drives the tone, noise and noise-control-decoder inputs, generates the one-cycle LFSR-reset pulse on noise register writes, and signals READY back to the host.

Parameters:
- COUNTER_BITS, 10, width of each tone period register.
- ATTN_BITS, 4, width of each attenuation register.
- READY_CYCLES, 32, clk cycles READY stays low after an accepted write (>=1).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous reset, active-high.
- data  input  8  host write data.
- we_n  input  1  host write strobe, active low.
- ready  output  1  high = next write will be accepted.
- tone0_freq  output  COUNTER_BITS  channel 0 tone period.
- tone1_freq  output  COUNTER_BITS  channel 1 tone period.
- tone2_freq  output  COUNTER_BITS  channel 2 tone period.
- attn0, attn1, attn2, attn3  output  ATTN_BITS each  channel attenuations; attn3 is noise.
- noise_control  output  3  {FB, NF1, NF0} to the noise control decoder.
- reset_lfsr  output  1  one-cycle pulse on every noise control write.

Behaviour:
- Reset values:
  - tone*_freq = 0; attn* = all ones (silent); noise_control = 0.
  - latch = {ch 0, tone}; ready = 1; reset_lfsr = 0; busy counter = 0.
  - we_n history = 1, so a low we_n at reset release is not treated as an edge.
- Strobe:
  - we_n is sampled every clk; an edge is prev=1, cur=0.
  - The edge is accepted only if ready=1. Edges while ready=0 are dropped with no state change.
  - A held-low we_n produces exactly one edge.
- Latch byte (data[7]=1):
  - latch <= data[6:4], where bits [6:5] are the channel and bit [4] is the type (1 = attenuation).
  - Type 0, ch 0-2: toneN_freq[3:0] <= data[3:0]; upper bits unchanged.
  - Type 1, any ch: attnN <= data[3:0].
  - Type 0, ch 3: noise_control <= data[2:0]; reset_lfsr pulses.
- Data byte (data[7]=0): acts on the current latch.
  - Tone ch 0-2: toneN_freq[9:4] <= data[5:0]; lower bits unchanged.
  - Attenuation: attnN <= data[3:0].
  - Noise: noise_control <= data[2:0]; reset_lfsr pulses.
  - The latch is unchanged by data bytes; repeated data bytes retarget the same register.
- Timing:
  - Register outputs update on the clk edge after the accepting sample (1-cycle latency).
  - reset_lfsr is high in that same cycle only.
  - ready goes low in that same cycle and stays low exactly READY_CYCLES cycles, then returns high. The busy counter saturates, with no wrap.
- Back-to-back noise writes spaced >= READY_CYCLES+1 cycles give one reset_lfsr pulse each.
- Reset asserted mid-busy clears to reset values immediately, ready=1 asynchronously, and aborts any pending pulse.
- All outputs are registered; there are no combinational paths from data or we_n to outputs.

Optional Feature:
- Macro: PSG_WE_SYNC_EN.
- Defined: we_n and data pass through a 2-flop synchronizer before edge detection, adding 2 cycles of latency (outputs update 3 clk edges after we_n falls). The host must hold data stable while we_n is low for >= 3 cycles.
- Undefined: we_n and data are treated as synchronous to clk, latency as specified above.

Decomposition:
- Shared package psg_pkg:
  - Register type codes (TONE=0, ATTN=1).
  - Channel index constants (NOISE_CH=3).
  - Reset constants (ATTN_SILENT=4'hF, NOISE_CTRL_RESET=3'b000).
  - Typedef for the 3-bit latch {ch[1:0], type}.
- One sub-module, psg_write_strobe: optional synchronizer plus falling-edge detect. Outputs a one-cycle write pulse and the captured data byte.

Test Plan:
- After reset, check outputs. Required: tone*=0, attn*=4'hF, noise_control=0, ready=1, reset_lfsr=0.
- Write 8'h8E then 8'h0F to ch0 tone. Required: tone0_freq=10'h0FE; ready is low for 32 cycles after each write; tone1 and tone2 remain 0.
- Write 8'hD5 (ch2 attenuation latch). Required: attn2=4'h5. Then write 8'h03 (data byte). Required: attn2=4'h3, and the latch is retained.
- Write 8'hE6 (noise, FB=1, NF=2'b10). Required: noise_control=3'b110 and exactly one reset_lfsr pulse. Then write 8'h01. Required: noise_control=3'b001 and a second pulse.
- Drive a second we_n fall 10 cycles after an accepted write. Required: it is ignored, with no register change and no pulse. Hold we_n low 100 cycles. Required: exactly one accept.
- Assert reset during the busy window, 5 cycles after a write. Required: ready=1 and attn*=4'hF immediately, with no reset_lfsr pulse.
